// File: rtl/hdmi_line_window.sv
// Line-buffer window for video streams: presents the live pixel together with
// the co-located pixels of up to NUM_TAPS-1 preceding lines of the same frame.
module hdmi_line_window #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_TAPS   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_vs,
    input  logic                           in_de,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_de,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
    output logic [NUM_TAPS-1:0]            out_tap_valid,
    output logic                           overflow
);

    localparam int LINE_DEPTH = 2 ** ADDR_WIDTH;
    localparam int STORES     = NUM_TAPS - 1;
    localparam int SLOT_W     = (STORES > 1) ? $clog2(STORES) : 1;
    localparam int CNT_W      = $clog2(NUM_TAPS);

    logic [DATA_WIDTH-1:0] mem [STORES][LINE_DEPTH];

    logic [ADDR_WIDTH:0]   col;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SLOT_W-1:0]     wr_slot;
    logic [CNT_W-1:0]      line_cnt;
    logic                  de_q;
    logic                  full;
    logic                  accept;
    logic                  eol;

    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_d;
    logic [NUM_TAPS-1:0]            valid_d;
    logic [SLOT_W-1:0]              rd_slot [NUM_TAPS];

    assign full   = col[ADDR_WIDTH];
    assign addr   = col[ADDR_WIDTH-1:0];
    assign accept = in_de & ~in_vs & ~full;
    assign eol    = de_q & ~in_de & ~in_vs;

    // Tap k reads the store written k lines ago; k = STORES lands on wr_slot
    // itself, whose old contents (read-first) are the oldest line.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            rd_slot[k] = SLOT_W'((int'(wr_slot) + STORES - k) % STORES);
        end
    end

    always_comb begin
        taps_d  = '0;
        valid_d = '0;
        if (accept) begin
            taps_d[DATA_WIDTH-1:0] = in_data;
            valid_d[0]             = 1'b1;
            for (int k = 1; k < NUM_TAPS; k++) begin
                if (int'(line_cnt) >= k) begin
                    valid_d[k] = 1'b1;
                    taps_d[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_slot[k]][addr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_slot][addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            wr_slot       <= '0;
            line_cnt      <= '0;
            de_q          <= 1'b0;
            overflow      <= 1'b0;
            out_de        <= 1'b0;
            out_taps      <= '0;
            out_tap_valid <= '0;
        end else begin
            out_de        <= accept;
            out_taps      <= taps_d;
            out_tap_valid <= valid_d;
            de_q          <= in_de & ~in_vs;
            if (in_vs) begin
                col      <= '0;
                wr_slot  <= '0;
                line_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (in_de && full) begin
                    overflow <= 1'b1;
                end
                if (accept) begin
                    col <= col + 1'b1;
                end else if (eol) begin
                    col <= '0;
                    if (wr_slot == SLOT_W'(STORES - 1)) begin
                        wr_slot <= '0;
                    end else begin
                        wr_slot <= wr_slot + 1'b1;
                    end
                    if (line_cnt != CNT_W'(STORES)) begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_line_window.sv
// Scoreboard bench: two window instances (defaults, and 8-deep / 5-tap)
// driven by one video stream, checked against a line-history model.
module tb_hdmi_line_window;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [23:0] data = '0;

    logic        de0, ovf0;
    logic [71:0] taps0;
    logic [2:0]  vld0;
    logic        de1, ovf1;
    logic [39:0] taps1;
    logic [4:0]  vld1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int L = 0;
    bit exp_ovf1 = 1'b0;
    logic [23:0] hist [16][16];

    typedef struct {
        int          cyc;
        logic [71:0] taps;
        logic [7:0]  vld;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    hdmi_line_window dut0 (
        .clk(clk), .rst_n(rst_n), .in_vs(vs), .in_de(de), .in_data(data),
        .out_de(de0), .out_taps(taps0), .out_tap_valid(vld0), .overflow(ovf0)
    );

    hdmi_line_window #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_TAPS(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_vs(vs), .in_de(de), .in_data(data[7:0]),
        .out_de(de1), .out_taps(taps1), .out_tap_valid(vld1), .overflow(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Tap k of line L, column c is simply line L-k's pixel at column c.
    function automatic exp_t mk(input int n, input int dw, input int c);
        exp_t e;
        logic [71:0] v;
        e.cyc  = cyc + 1;
        e.taps = '0;
        e.vld  = '0;
        for (int k = 0; k < n; k++) begin
            if (L >= k) begin
                e.vld[k] = 1'b1;
                v = 72'(hist[(L - k) % 16][c]);
                if (dw == 8) v = v & 72'hff;
                e.taps = e.taps | (v << (k * dw));
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q0.size() > 0 && q0[0].cyc < cyc) begin
            chk("missing_out0", 0, 1);
            void'(q0.pop_front());
        end
        if (de0) begin
            if (q0.size() == 0 || q0[0].cyc != cyc) begin
                chk("unexpected_de0", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("taps0", taps0, e.taps);
                chk("vld0", 72'(vld0), e.taps == e.taps ? 72'(e.vld[2:0]) : 72'(0));
            end
        end else begin
            chk("idle0", taps0 | 72'(vld0), 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (q1.size() > 0 && q1[0].cyc < cyc) begin
            chk("missing_out1", 0, 1);
            void'(q1.pop_front());
        end
        if (de1) begin
            if (q1.size() == 0 || q1[0].cyc != cyc) begin
                chk("unexpected_de1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("taps1", 72'(taps1), e.taps);
                chk("vld1", 72'(vld1), 72'(e.vld[4:0]));
            end
        end else begin
            chk("idle1", 72'(taps1) | 72'(vld1), 0);
        end
    end

    task automatic fill(input bit pattern);
        for (int c = 0; c < 16; c++) begin
            hist[L % 16][c] = pattern ? 24'(L * 16 + c) : 24'($urandom);
        end
    endtask

    task automatic pixel(input int c);
        @(negedge clk);
        de   = 1'b1;
        data = hist[L % 16][c];
        q0.push_back(mk(3, 24, c));
        if (c < 8) q1.push_back(mk(5, 8, c));
        else exp_ovf1 = 1'b1;
    endtask

    task automatic drive_line(input int len, input int gap);
        for (int c = 0; c < len; c++) pixel(c);
        @(negedge clk);
        de = 1'b0;
        L++;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_vs();
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        L = 0;
        exp_ovf1 = 1'b0;
    endtask

    task automatic frame_end();
        chk("ovf0", 72'(ovf0), 0);
        chk("ovf1", 72'(ovf1), 72'(exp_ovf1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int len;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_de0", 72'(de0), 0);
        chk("rst_out0", taps0 | 72'(vld0) | 72'(ovf0), 0);
        chk("rst_out1", 72'(taps1) | 72'(vld1) | 72'(ovf1) | 72'(de1), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Patterned frame: line L pixel c = L*16+c.
        do_vs();
        for (int i = 0; i < 3; i++) begin
            fill(1'b1);
            drive_line(8, 1);
        end
        frame_end();

        // Seven lines so the 5-tap ring wraps.
        do_vs();
        for (int i = 0; i < 7; i++) begin
            fill(1'b0);
            drive_line(8, i % 3);
        end
        frame_end();

        // Over-long lines overflow the 8-deep instance only.
        do_vs();
        for (int i = 0; i < 3; i++) begin
            fill(1'b0);
            drive_line(10, 1);
        end
        frame_end();
        chk("ovf1_set", 72'(ovf1), 1);
        do_vs();
        @(negedge clk);
        chk("ovf1_clr", 72'(ovf1), 0);

        // Frame start coincident with a pixel: pixel dropped, no line counted.
        @(negedge clk);
        vs   = 1'b1;
        de   = 1'b1;
        data = 24'($urandom);
        @(negedge clk);
        vs = 1'b0;
        de = 1'b0;
        L = 0;
        exp_ovf1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            fill(1'b0);
            drive_line(6, 1);
        end
        frame_end();

        // Reset in the middle of line 2.
        do_vs();
        for (int i = 0; i < 2; i++) begin
            fill(1'b0);
            drive_line(6, 1);
        end
        fill(1'b0);
        for (int c = 0; c < 3; c++) pixel(c);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        de = 1'b0;
        #1;
        chk("midrst_de", 72'(de0) | 72'(de1), 0);
        chk("midrst_out0", taps0 | 72'(vld0), 0);
        chk("midrst_out1", 72'(taps1) | 72'(vld1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        L = 0;
        exp_ovf1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            fill(1'b0);
            drive_line(6, 1);
        end
        frame_end();

        // Random frames, line lengths non-increasing within a frame.
        for (int f = 0; f < 12; f++) begin
            do_vs();
            n   = $urandom_range(1, 9);
            len = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                fill(1'b0);
                drive_line(len, $urandom_range(0, 3));
                len = $urandom_range(1, len);
            end
            frame_end();
        end

        repeat (4) @(negedge clk);
        chk("q0_drained", 72'(q0.size()), 0);
        chk("q1_drained", 72'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
